// File: rtl/glip_upscale_if.sv
// Valid/ready stream bundle for the GLIP upscaler.
// The same interface carries the narrow link-side stream and the wide
// logic-side stream; WIDTH sets the data width of each instance.
interface glip_upscale_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] data;
   logic             valid;
   logic             ready;

   // producer side: drives data/valid and observes ready
   modport master (
      output data,
      output valid,
      input  ready
   );

   // consumer side: observes data/valid and drives ready
   modport slave (
      input  data,
      input  valid,
      output ready
   );
endinterface

// File: rtl/glip_upscale.sv
// GLIP upscaler: packs two consecutive narrow transfers into one wide word.
// The first narrow word lands in the upper half and the second in the lower
// half. The wide word sits in an output register that holds still under
// backpressure. At most one narrow word (the next upper half) is taken while
// that register is stalled, so nothing is ever overwritten.
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_EMPTY | no half word held; the next accepted word is the upper
// ST_HALF  | upper half held; the next accepted word completes it
module glip_upscale #(
   parameter int IN_SIZE = 16
) (
   input  logic            clk,
   input  logic            rst,
   glip_upscale_if.slave   in_s,
   glip_upscale_if.master  out_m,
   output logic            pending
);
   localparam int OUT_SIZE = 2 * IN_SIZE;

   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_HALF  = 1'b1;

   logic [0:0]          state;
   logic [IN_SIZE-1:0]  upper;
   logic [OUT_SIZE-1:0] out_q;
   logic                out_vld;

   logic upper_vld;
   logic in_rdy;
   logic accept;
   logic drain;
   logic load;

   assign upper_vld = (state == ST_HALF);

   // In ST_EMPTY the next word can always be taken because it only fills the
   // upper register. In ST_HALF the word completes a wide word, so it needs
   // room in the output register. in_valid deliberately plays no part here.
   assign in_rdy = !upper_vld || !out_vld || out_m.ready;

   assign accept = in_s.valid && in_rdy;
   assign drain  = out_vld && out_m.ready;
   assign load   = accept && upper_vld;

   assign in_s.ready  = in_rdy;
   assign out_m.data  = out_q;
   assign out_m.valid = out_vld;
   assign pending     = upper_vld;

   // Half-word state machine and the held upper half.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_EMPTY;
         upper <= '0;
      end else if (accept) begin
         case (state)
            ST_EMPTY: begin
               upper <= in_s.data;
               state <= ST_HALF;
            end
            default: begin
               state <= ST_EMPTY;
            end
         endcase
      end
   end

   // Output register: a load wins over a drain in the same cycle, so valid
   // stays high and the new word replaces the one just taken by the sink.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_q   <= '0;
         out_vld <= 1'b0;
      end else if (load) begin
         out_q   <= {upper, in_s.data};
         out_vld <= 1'b1;
      end else if (drain) begin
         out_vld <= 1'b0;
      end
   end
endmodule

// File: tb/tb_glip_upscale.sv
// Self-checking bench for glip_upscale with a packing scoreboard.
module tb_glip_upscale;
   localparam int IN_SIZE  = 16;
   localparam int OUT_SIZE = 2 * IN_SIZE;

   logic clk;
   logic rst;
   logic pending;

   glip_upscale_if #(.WIDTH(IN_SIZE))  in_if ();
   glip_upscale_if #(.WIDTH(OUT_SIZE)) out_if ();

   glip_upscale #(.IN_SIZE(IN_SIZE)) dut (
      .clk     (clk),
      .rst     (rst),
      .in_s    (in_if),
      .out_m   (out_if),
      .pending (pending)
   );

   int checks = 0;
   int errors = 0;

   logic [OUT_SIZE-1:0] sb_q[$];
   logic [IN_SIZE-1:0]  m_upper;
   logic                m_half;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard: inputs change just after posedge, so at negedge all
   // handshake signals show what the next posedge will act on.
   always @(negedge clk) begin
      if (!rst) begin
         sb_q.delete();
         m_half  = 1'b0;
         m_upper = '0;
      end else begin
         checks++;
         if (pending !== m_half) begin
            errors++;
            $display("FAIL sb_pending: got %b expected %b at %0t", pending, m_half, $time);
         end
         checks++;
         if (out_if.valid !== (sb_q.size() != 0)) begin
            errors++;
            $display("FAIL sb_out_valid: got %b expected %b at %0t", out_if.valid, (sb_q.size() != 0), $time);
         end
         checks++;
         if (in_if.ready !== (!m_half || !out_if.valid || out_if.ready)) begin
            errors++;
            $display("FAIL sb_in_ready: got %b expected %b at %0t", in_if.ready,
                     (!m_half || !out_if.valid || out_if.ready), $time);
         end
         if (out_if.valid === 1'b1 && out_if.ready === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL sb_drain: got unexpected word %h expected none at %0t", out_if.data, $time);
            end else begin
               logic [OUT_SIZE-1:0] exp_w;
               exp_w = sb_q.pop_front();
               if (out_if.data !== exp_w) begin
                  errors++;
                  $display("FAIL sb_data: got %h expected %h at %0t", out_if.data, exp_w, $time);
               end
            end
         end
         if (in_if.valid === 1'b1 && in_if.ready === 1'b1) begin
            if (!m_half) begin
               m_upper = in_if.data;
               m_half  = 1'b1;
            end else begin
               sb_q.push_back({m_upper, in_if.data});
               m_half = 1'b0;
            end
         end
      end
   end

   // Offer one word and return just after the posedge that accepted it.
   task automatic send_word(input logic [IN_SIZE-1:0] d);
      bit ok;
      ok = 1'b0;
      in_if.data  = d;
      in_if.valid = 1'b1;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (in_if.ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL send_timeout: word %h got in_ready=0 expected 1 within 50 cycles", d);
      end
      @(posedge clk);
      #1;
      in_if.valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (out_if.valid !== 1'b0 || pending !== 1'b0 || in_if.ready !== 1'b1 || out_if.data !== '0) begin
            errors++;
            $display("FAIL reset_state: got valid=%b pending=%b ready=%b data=%h expected 0 0 1 0",
                     out_if.valid, pending, in_if.ready, out_if.data);
         end
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (out_if.valid !== 1'b0 || pending !== 1'b0 || in_if.ready !== 1'b1 || out_if.data !== '0) begin
            errors++;
            $display("FAIL idle_state: got valid=%b pending=%b ready=%b data=%h expected 0 0 1 0",
                     out_if.valid, pending, in_if.ready, out_if.data);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      out_if.ready = 1'b1;
      send_word(16'hAAAA);
      checks++;
      if (pending !== 1'b1 || out_if.valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_half: got pending=%b valid=%b expected 1 0", pending, out_if.valid);
      end
      send_word(16'h5555);
      checks++;
      if (out_if.valid !== 1'b1 || out_if.data !== 32'hAAAA5555 || pending !== 1'b0) begin
         errors++;
         $display("FAIL basic_pack: got valid=%b data=%h pending=%b expected 1 aaaa5555 0",
                  out_if.valid, out_if.data, pending);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_if.valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_one_cycle: got valid=%b expected 0", out_if.valid);
      end
   endtask

   task automatic test_stream();
      out_if.ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_if.valid = 1'b1;
         in_if.data  = IN_SIZE'(i + 1);
         @(negedge clk);
         checks++;
         if (in_if.ready !== 1'b1) begin
            errors++;
            $display("FAIL stream_ready: word %0d got in_ready=%b expected 1", i + 1, in_if.ready);
         end
         @(posedge clk);
         #1;
         checks++;
         if (i % 2 == 1) begin
            if (out_if.valid !== 1'b1 || out_if.data !== {IN_SIZE'(i), IN_SIZE'(i + 1)}) begin
               errors++;
               $display("FAIL stream_out: got valid=%b data=%h expected 1 %h",
                        out_if.valid, out_if.data, {IN_SIZE'(i), IN_SIZE'(i + 1)});
            end
         end else if (out_if.valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_gap: got valid=%b expected 0", out_if.valid);
         end
      end
      in_if.valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_backpressure();
      out_if.ready = 1'b0;
      send_word(16'h1111);
      send_word(16'h2222);
      send_word(16'h3333);
      in_if.data  = 16'h4444;
      in_if.valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (in_if.ready !== 1'b0 || out_if.valid !== 1'b1 || out_if.data !== 32'h11112222 || pending !== 1'b1) begin
            errors++;
            $display("FAIL bp_stall: got ready=%b valid=%b data=%h pending=%b expected 0 1 11112222 1",
                     in_if.ready, out_if.valid, out_if.data, pending);
         end
      end
      @(posedge clk);
      #1;
      out_if.ready = 1'b1;
      @(negedge clk);
      checks++;
      if (in_if.ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_release: got in_ready=%b expected 1", in_if.ready);
      end
      @(posedge clk);
      #1;
      in_if.valid = 1'b0;
      checks++;
      if (out_if.valid !== 1'b1 || out_if.data !== 32'h33334444 || pending !== 1'b0) begin
         errors++;
         $display("FAIL bp_next: got valid=%b data=%h pending=%b expected 1 33334444 0",
                  out_if.valid, out_if.data, pending);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_if.valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_drained: got valid=%b expected 0", out_if.valid);
      end
   endtask

   task automatic test_drain_load();
      out_if.ready = 1'b0;
      send_word(16'h0A0A);
      send_word(16'h0B0B);
      send_word(16'h0C0C);
      in_if.data   = 16'h0D0D;
      in_if.valid  = 1'b1;
      out_if.ready = 1'b1;
      @(posedge clk);
      #1;
      in_if.valid = 1'b0;
      checks++;
      if (out_if.valid !== 1'b1 || out_if.data !== 32'h0C0C0D0D) begin
         errors++;
         $display("FAIL drain_load: got valid=%b data=%h expected 1 0c0c0d0d", out_if.valid, out_if.data);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid();
      out_if.ready = 1'b1;
      send_word(16'hDEAD);
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if (pending !== 1'b0 || in_if.ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_async: got pending=%b ready=%b expected 0 1", pending, in_if.ready);
      end
      @(negedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      send_word(16'hBEEF);
      send_word(16'hCAFE);
      checks++;
      if (out_if.valid !== 1'b1 || out_if.data !== 32'hBEEFCAFE) begin
         errors++;
         $display("FAIL rst_discard: got valid=%b data=%h expected 1 beefcafe", out_if.valid, out_if.data);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         in_if.valid  = ($urandom_range(0, 3) != 0);
         in_if.data   = IN_SIZE'($urandom);
         out_if.ready = ($urandom_range(0, 2) != 0);
         @(posedge clk);
         #1;
      end
      in_if.valid  = 1'b0;
      out_if.ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (sb_q.size() != 0 || out_if.valid !== 1'b0) begin
         errors++;
         $display("FAIL random_flush: got %0d words left valid=%b expected 0 0", sb_q.size(), out_if.valid);
      end
   endtask

   initial begin
      rst          = 1'b0;
      in_if.data   = '0;
      in_if.valid  = 1'b0;
      out_if.ready = 1'b0;
      test_reset();
      test_basic();
      test_stream();
      test_backpressure();
      test_drain_load();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
